// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Purpose  : Direct-mapped, one-word-per-line instruction cache with
//            combinational hits and a stall-until-ready miss fill.
//            Optional macro ICACHE_FWD_EN forwards fill data in the fill cycle.
// Revision : 1.0 - initial release
// ============================================================================
module icache_dm #(
    parameter int NLINES = 16,
    parameter int IDXW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_rdy,
    input  logic        inv,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data
);

    localparam int C_TAGW = 32 - IDXW - 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         miss_addr_q, miss_addr_d;
    logic [NLINES-1:0]   valid_q, valid_d;
    logic [C_TAGW-1:0]   tag_q  [NLINES];
    logic [31:0]         data_q [NLINES];

    logic [IDXW-1:0]     w_idx;
    logic [C_TAGW-1:0]   w_tag;
    logic [IDXW-1:0]     w_miss_idx;
    logic                w_hit;
    logic                w_fill_we;

    assign w_idx      = cpu_addr[IDXW+1:2];
    assign w_tag      = cpu_addr[31:IDXW+2];
    assign w_miss_idx = miss_addr_q[IDXW+1:2];
    assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        w_fill_we   = 1'b0;
        mem_addr    = cpu_addr;
        cpu_rdy     = 1'b0;
        cpu_data    = 32'h0;

        case (state_q)
            S_IDLE: begin
                // Drive the fetch address straight through so memory starts early
                cpu_rdy = w_hit;
                if (w_hit) begin
                    cpu_data = data_q[w_idx];
                end else begin
                    miss_addr_d = cpu_addr;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                mem_addr = miss_addr_q;
                if (mem_rdy) begin
                    w_fill_we            = 1'b1;
                    valid_d[w_miss_idx]  = 1'b1;
                    state_d              = S_IDLE;
`ifdef ICACHE_FWD_EN
                    if (cpu_addr[31:2] == miss_addr_q[31:2]) begin
                        cpu_rdy  = 1'b1;
                        cpu_data = mem_data;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Invalidate wins over a fill landing in the same cycle
        if (inv) begin
            valid_d = '0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            miss_addr_q <= 32'h0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Payload arrays need no reset: a line is only visible through its valid bit
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            data_q[w_miss_idx] <= mem_data;
            tag_q[w_miss_idx]  <= miss_addr_q[31:IDXW+2];
        end
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, one-word-per-line instruction cache between the CPU fetch stage and the slow instruction memory.
- Serves hits combinationally in the same cycle.
- On a miss, holds a stable address to the slow memory until its ready flag rises, fills the line, then serves the hit.
- Hides the multi-cycle memory latency for loops and repeated fetches.

Parameters:
- NLINES, 16, number of cache lines; power of 2, at least 2.
- IDXW, 4, index width; must equal log2(NLINES).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_addr  input  32  fetch byte address; bits [1:0] ignored.
- cpu_data  output  32  instruction word; 0 when cpu_rdy=0.
- cpu_rdy  output  1  1 = cpu_data valid for cpu_addr this cycle; 0 = stall.
- inv  input  1  synchronous invalidate-all request.
- mem_addr  output  32  address to slow memory.
- mem_rdy  input  1  slow memory data valid for mem_addr.
- mem_data  input  32  slow memory read data.

Behaviour:
- Reset is asynchronous and active-low (rst_n); single clock clk.
- rst_n=0 clears all valid bits and forces state IDLE.
- Outputs during and after reset: cpu_rdy=0, cpu_data=0, mem_addr=cpu_addr.
- Address split: index = cpu_addr[IDXW+1:2]; tag = cpu_addr[31:IDXW+2].
- Storage: data and tag arrays plus a valid array, all registers, no memory macro.
- hit = valid[index] & (tag_array[index] == tag).

States:
- IDLE:
  - mem_addr = cpu_addr, so the slow memory starts counting immediately.
  - cpu_rdy = hit; cpu_data = data_array[index] if hit, else 0.
  - On miss: latch miss_addr <= cpu_addr, go to FILL.
- FILL:
  - mem_addr = miss_addr, held stable every cycle.
  - cpu_rdy = 0 (unless ICACHE_FWD_EN applies).
  - On mem_rdy=1: write mem_data and the tag of miss_addr at miss_addr's index, set its valid bit, go to IDLE.
  - While mem_rdy=0: remain in FILL.
- mem_rdy is ignored in IDLE.

Timing:
- Hit latency is 0 cycles (combinational).
- Miss: cpu_rdy is first 1 in the cycle after the mem_rdy-capture edge.

Boundary rules:
- If cpu_addr changes during FILL (branch redirect), the fill still completes for miss_addr. The new address is then looked up in IDLE.
- inv=1: all valid bits cleared at the next edge; state forced to IDLE.
- inv has priority over a simultaneous fill. The filled line ends invalid, so the next lookup misses again.
- Index aliasing: a fill overwrites the existing line (no associativity, no replacement policy).
- Reset mid-FILL: fill abandoned, nothing written, state IDLE.
- Address wraps naturally at 32 bits; no special handling.

Optional Feature:
- Macro: ICACHE_FWD_EN.
- Defined: in FILL, when mem_rdy=1 and cpu_addr[31:2]==miss_addr[31:2], cpu_rdy=1 and cpu_data=mem_data in that same cycle. The line is written as normal. This saves one cycle per miss.
- Undefined: cpu_rdy=0 throughout FILL; data is served from the array in the following IDLE cycle.

Test Plan:
- Cold miss:
  - Stimulus: reset, cpu_addr=0x00000010, bench model asserts mem_rdy with mem_data=0x8C220004 on the 3rd FILL cycle.
  - Required: mem_addr=0x00000010 stable throughout; cpu_rdy=0 until FILL ends. Next cycle cpu_rdy=1, cpu_data=0x8C220004. With ICACHE_FWD_EN, cpu_rdy=1 one cycle earlier.
- Repeat hit:
  - Stimulus: loop 0x10, 0x14, 0x10, 0x14 after both lines are filled.
  - Required: cpu_rdy=1 every cycle, correct data, no FILL entry.
- Conflict:
  - Stimulus: fill 0x00000010, then fetch 0x00000050 (same index 4 when NLINES=16).
  - Required: miss, FILL, line replaced. Refetching 0x10 misses again.
- Redirect mid-fill:
  - Stimulus: miss on 0x20, change cpu_addr to 0x100 during FILL.
  - Required: mem_addr stays 0x20 until mem_rdy, then 0x20 line is valid. 0x100 then misses and fills; a later fetch of 0x20 hits.
- Invalidate with simultaneous fill:
  - Stimulus: inv=1 on the mem_rdy cycle of a fill of 0x30.
  - Required: state IDLE, all lines invalid; fetch of 0x30 misses.
- Async reset:
  - Stimulus: assert rst_n=0 between clock edges during FILL.
  - Required: cpu_rdy=0 immediately, state IDLE; previously cached addresses miss after release.
